// File: rtl/allpass_coef_loader.sv
// allpass_coef_loader
// Writer side of the allpass coefficient bus. Coefficient words arrive on a
// valid/ready stream, are staged in a shadow bank, and a complete frame is
// committed to c_out in a single cycle so the filter never sees a partial set.
// Optional feature: define ALLPASS_COEF_CSUM_EN to require a trailing
// checksum word (sum of the N coefficients mod 2^WIDTH) before committing.

module allpass_coef_loader #(
  parameter int WIDTH = 16,
  parameter int N     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH-1:0]   s_data,
  input  logic               s_last,
  output logic [WIDTH*N-1:0] c_out,
  output logic               c_update,
  output logic               busy,
  output logic               err
);

  // idx must be able to count up to N so the checksum position is reachable
  localparam int IW = $clog2(N + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
`ifdef ALLPASS_COEF_CSUM_EN
  localparam logic [IW-1:0] CSUM_IDX = IW'(N);
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    COMMIT
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] shadow [N];
  logic             accept;
`ifdef ALLPASS_COEF_CSUM_EN
  logic [WIDTH-1:0] sum;
`endif

  // The loader only refuses words while the commit cycle is in progress
  assign s_ready = (state != COMMIT);
  assign busy    = (state != IDLE);
  assign accept  = s_valid && s_ready;

  // Frame collection, validation and single-cycle commit of the shadow bank
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      c_out    <= '0;
      c_update <= 1'b0;
      err      <= 1'b0;
      for (int k = 0; k < N; k++) begin
        shadow[k] <= '0;
      end
`ifdef ALLPASS_COEF_CSUM_EN
      sum      <= '0;
`endif
    end else begin
      c_update <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
`ifdef ALLPASS_COEF_CSUM_EN
            if (idx == CSUM_IDX) begin
              idx <= '0;
              if (s_last) begin
                if (s_data == sum) begin
                  state <= COMMIT;
                end else begin
                  err   <= 1'b1;
                  state <= IDLE;
                end
              end else begin
                state <= DRAIN;
              end
            end else begin
              for (int k = 0; k < N; k++) begin
                if (idx == IW'(k)) begin
                  shadow[k] <= s_data;
                end
              end
              sum <= (idx == '0) ? s_data : sum + s_data;
              if (s_last) begin
                err   <= 1'b1;
                state <= IDLE;
                idx   <= '0;
              end else begin
                idx   <= idx + 1'b1;
                state <= LOAD;
              end
            end
`else
            for (int k = 0; k < N; k++) begin
              if (idx == IW'(k)) begin
                shadow[k] <= s_data;
              end
            end
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= s_last ? COMMIT : DRAIN;
            end else if (s_last) begin
              err   <= 1'b1;
              state <= IDLE;
              idx   <= '0;
            end else begin
              idx   <= idx + 1'b1;
              state <= LOAD;
            end
`endif
          end
        end
        DRAIN: begin
          if (accept && s_last) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        COMMIT: begin
          for (int k = 0; k < N; k++) begin
            c_out[k*WIDTH +: WIDTH] <= shadow[k];
          end
          c_update <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_allpass_coef_loader.sv
// tb_allpass_coef_loader
// Directed and randomized stimulus for allpass_coef_loader, checked cycle by
// cycle against a frame-level reference model (queue of accepted words,
// judged when s_last arrives). Honours ALLPASS_COEF_CSUM_EN if defined.

module tb_allpass_coef_loader;

  localparam int W = 16;
  localparam int N = 5;
`ifdef ALLPASS_COEF_CSUM_EN
  localparam int FL = N + 1;
`else
  localparam int FL = N;
`endif

  logic           clk;
  logic           rst;
  logic           s_valid;
  logic           s_ready;
  logic [W-1:0]   s_data;
  logic           s_last;
  logic [W*N-1:0] c_out;
  logic           c_update;
  logic           busy;
  logic           err;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [W-1:0]   q [$];
  logic           m_ready   = 1'b1;
  logic [W*N-1:0] m_c       = '0;
  logic [W*N-1:0] m_pend    = '0;
  logic           m_upd     = 1'b0;
  logic           m_err     = 1'b0;
  logic           m_pending = 1'b0;

  allpass_coef_loader #(.WIDTH(W), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .c_out    (c_out),
    .c_update (c_update),
    .busy     (busy),
    .err      (err)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a frame is good when it has exactly FL words (and a matching checksum)
  function automatic logic frame_good();
`ifdef ALLPASS_COEF_CSUM_EN
    logic [W-1:0] s;
    if (q.size() != FL) return 1'b0;
    s = '0;
    for (int i = 0; i < N; i++) s = s + q[i];
    return (s == q[N]);
`else
    return (q.size() == FL);
`endif
  endfunction

  function automatic logic [W-1:0] queue_sum();
    logic [W-1:0] s;
    s = '0;
    foreach (q[i]) s = s + q[i];
    return s;
  endfunction

  // what one rising edge does, described at frame level
  task automatic model_edge(input logic v, input logic [W-1:0] d, input logic l, input logic r);
    if (r) begin
      q.delete();
      m_ready = 1'b1; m_c = '0; m_upd = 1'b0; m_err = 1'b0; m_pending = 1'b0;
    end else begin
      m_upd = 1'b0;
      m_err = 1'b0;
      if (m_pending) begin
        m_c = m_pend; m_upd = 1'b1; m_pending = 1'b0; m_ready = 1'b1;
      end else if (v && m_ready) begin
        q.push_back(d);
        if (l) begin
          if (frame_good()) begin
            for (int k = 0; k < N; k++) m_pend[k*W +: W] = q[k];
            m_pending = 1'b1;
            m_ready   = 1'b0;
          end else begin
            m_err = 1'b1;
          end
          q.delete();
        end
      end
    end
  endtask

  task automatic check_output(input string tag, input logic [W*N-1:0] got, input logic [W*N-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drive one cycle, advance the model across the edge, compare 1 ns later
  task automatic apply_stimulus(input logic v, input logic [W-1:0] d, input logic l, input logic r);
    s_valid = v; s_data = d; s_last = l; rst = r;
    @(posedge clk);
    model_edge(v, d, l, r);
    #1;
    check_output("c_out",    c_out,           m_c);
    check_output("c_update", {79'd0, c_update}, {79'd0, m_upd});
    check_output("err",      {79'd0, err},      {79'd0, m_err});
    check_output("s_ready",  {79'd0, s_ready},  {79'd0, m_ready});
    check_output("busy",     {79'd0, busy},     {79'd0, (q.size() != 0) || m_pending});
    check_output("excl",     {79'd0, c_update & err}, '0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  // a well-formed frame, with checksum word appended when enabled
  task automatic send_good(input logic [W-1:0] w [N], input int gap_after, input int gap_len);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s = s + w[i];
      apply_stimulus(1'b1, w[i], (FL == N) && (i == N - 1), 1'b0);
      if (i == gap_after) idle_cycles(gap_len);
    end
`ifdef ALLPASS_COEF_CSUM_EN
    apply_stimulus(1'b1, s, 1'b1, 1'b0);
`endif
  endtask

  logic [W-1:0] f_inc [N];
  logic [W-1:0] f_ones [N];

  initial begin
    int tgt;
    logic v, l, r;
    logic [W-1:0] d;

    f_inc  = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    f_ones = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; rst = 1'b1;

    $display("[TB] reset");
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    idle_cycles(2);

    $display("[TB] frame with a 3-cycle stall, then back-to-back frame");
    send_good(f_inc, 2, 3);
    idle_cycles(2);
    send_good(f_inc, -1, 0);
    idle_cycles(2);

    $display("[TB] short frame then good frame");
    apply_stimulus(1'b1, 16'h7FFF, 1'b0, 1'b0);
    apply_stimulus(1'b1, 16'h8000, 1'b0, 1'b0);
    apply_stimulus(1'b1, 16'h1234, 1'b1, 1'b0);
    idle_cycles(1);
    send_good(f_ones, -1, 0);
    idle_cycles(2);
    send_good(f_inc, -1, 0);
    idle_cycles(2);

    $display("[TB] long frame");
    for (int i = 0; i < 7; i++) apply_stimulus(1'b1, 16'(16'h0100 + i), i == 6, 1'b0);
    idle_cycles(2);

    $display("[TB] single-word frame");
    apply_stimulus(1'b1, 16'hABCD, 1'b1, 1'b0);
    idle_cycles(1);

    $display("[TB] reset mid-frame");
    apply_stimulus(1'b1, 16'h1111, 1'b0, 1'b0);
    apply_stimulus(1'b1, 16'h2222, 1'b0, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    idle_cycles(1);
    send_good(f_ones, -1, 0);
    idle_cycles(2);

`ifdef ALLPASS_COEF_CSUM_EN
    $display("[TB] checksum match and mismatch");
    for (int i = 0; i < N; i++) apply_stimulus(1'b1, f_inc[i], 1'b0, 1'b0);
    apply_stimulus(1'b1, 16'h000F, 1'b1, 1'b0);
    idle_cycles(2);
    for (int i = 0; i < N; i++) apply_stimulus(1'b1, 16'(f_inc[i] + 16'h0010), 1'b0, 1'b0);
    apply_stimulus(1'b1, 16'h0010, 1'b1, 1'b0);
    idle_cycles(2);
`endif

    $display("[TB] randomized frames");
    tgt = FL;
    for (int step = 0; step < 600; step++) begin
      if (q.size() == 0) tgt = ($urandom_range(0, 9) < 7) ? FL : int'($urandom_range(1, FL + 3));
      v = ($urandom_range(0, 4) != 0);
      d = W'($urandom);
`ifdef ALLPASS_COEF_CSUM_EN
      if (q.size() == N && tgt == FL && $urandom_range(0, 4) != 0) d = queue_sum();
`endif
      l = (q.size() + 1 == tgt);
      r = ($urandom_range(0, 99) == 0);
      apply_stimulus(v, d, l, r);
    end
    idle_cycles(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
